if_fetch_stage: RTL

Instruction-fetch stage of the pipelined RV32 core. It holds the program counter and forms PC+4. It issues req/rdy fetches to instruction memory and fills the IF/ID pipeline register. Its PC and PC+4 outputs feed the downstream 32-bit adders that compute branch/jump targets in ID/EX.

---
 rtl/if_pkg.sv | 29 ++
 rtl/if_id_reg.sv | 50 +++++
 rtl/if_fetch_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared types and constants for the instruction-fetch stage.
//   if_state_e        : fetch controller states (FETCH, DRAIN, HOLD)
//   INST_W            : instruction / address width
//   NOP_INST_DEFAULT  : addi x0,x0,0, placed in IF/ID on reset or flush
//   RESET_PC_DEFAULT  : program counter after reset
//   add32()           : the core's common 32-bit modulo-2^32 adder
// -----------------------------------------------------------------------------
package if_pkg;

    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0013;
    localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } if_state_e;

    // Carry out is deliberately dropped: address arithmetic wraps at 2^32.
    function automatic logic [INST_W-1:0] add32(input logic [INST_W-1:0] a,
                                                input logic [INST_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with load / bubble / flush controls.
// Priority: flush > load > bubble > hold.
//   clk, rst            : clock, asynchronous active-low reset
//   load                : capture {1, load_pc, load_pc4, load_inst}
//   bubble              : clear valid only, other fields keep their value
//   flush               : clear valid and replace the instruction with NOP_INST
//   load_pc/pc4/inst    : data to capture on load
//   valid, pc, pc4, inst: register contents
// -----------------------------------------------------------------------------
module if_id_reg
    import if_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic              flush,
    input  logic [INST_W-1:0] load_pc,
    input  logic [INST_W-1:0] load_pc4,
    input  logic [INST_W-1:0] load_inst,
    output logic              valid,
    output logic [INST_W-1:0] pc,
    output logic [INST_W-1:0] pc4,
    output logic [INST_W-1:0] inst
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            pc    <= '0;
            pc4   <= '0;
            inst  <= NOP_INST;
        end else if (flush) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            pc4   <= load_pc4;
            inst  <= load_inst;
        end else if (bubble) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage of the RV32 pipeline: owns the PC, issues req/rdy
// fetches to instruction memory and fills the IF/ID register.
//   clk, rst        : clock, asynchronous active-low reset
//   imem_req/addr   : fetch request and address (pc, or drain_addr in DRAIN)
//   imem_rdy/inst   : response handshake and instruction word
//   id_stall        : ID cannot accept, IF/ID holds
//   redirect/_pc    : taken branch/jump from EX, highest priority after reset
//   pc_out          : current pc register
//   if_id_*         : IF/ID register outputs (valid, pc, pc+4, instruction)
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt.
// -----------------------------------------------------------------------------
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [INST_W-1:0] imem_addr,
    input  logic              imem_rdy,
    input  logic [INST_W-1:0] imem_inst,
    input  logic              id_stall,
    input  logic              redirect,
    input  logic [INST_W-1:0] redirect_pc,
    output logic [INST_W-1:0] pc_out,
    output logic              if_id_valid,
    output logic [INST_W-1:0] if_id_pc,
    output logic [INST_W-1:0] if_id_pc4,
    output logic [INST_W-1:0] if_id_inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    if_state_e         state, state_nxt;
    logic [INST_W-1:0] pc, pc_nxt;
    logic [INST_W-1:0] drain_addr, drain_nxt;
    logic [INST_W-1:0] buf_pc, buf_inst;
    logic              buf_ld;

    logic              id_load, id_bubble, id_flush;
    logic [INST_W-1:0] ld_pc, ld_pc4, ld_inst;

    logic [INST_W-1:0] pc_plus4, buf_pc4;

    assign pc_plus4 = add32(pc, 32'd4);
    assign buf_pc4  = add32(buf_pc, 32'd4);
    assign pc_out   = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drain_addr <= drain_nxt;
        end
    end

    // Skid buffer: parks one response that arrived while ID was stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_pc   <= '0;
            buf_inst <= '0;
        end else if (buf_ld) begin
            buf_pc   <= pc;
            buf_inst <= imem_inst;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drain_nxt = drain_addr;
        buf_ld    = 1'b0;
        id_load   = 1'b0;
        id_bubble = 1'b0;
        id_flush  = 1'b0;
        ld_pc     = pc;
        ld_pc4    = pc_plus4;
        ld_inst   = imem_inst;
        imem_req  = 1'b1;
        imem_addr = pc;

        case (state)
            FETCH: begin
                if (redirect) begin
                    pc_nxt   = redirect_pc;
                    id_flush = 1'b1;
                    // Request at the old pc is still in flight; it must
                    // complete before the new target can be requested.
                    if (!imem_rdy) begin
                        drain_nxt = pc;
                        state_nxt = DRAIN;
                    end
                end else if (imem_rdy && !id_stall) begin
                    id_load = 1'b1;
                    pc_nxt  = pc_plus4;
                end else if (imem_rdy) begin
                    buf_ld    = 1'b1;
                    pc_nxt    = pc_plus4;
                    state_nxt = HOLD;
                end else if (!id_stall) begin
                    id_bubble = 1'b1;
                end
            end

            DRAIN: begin
                imem_addr = drain_addr;
                if (redirect) begin
                    pc_nxt   = redirect_pc;
                    id_flush = 1'b1;
                end else if (!id_stall) begin
                    id_bubble = 1'b1;
                end
                if (imem_rdy) begin
                    state_nxt = FETCH;
                end
            end

            HOLD: begin
                imem_req = 1'b0;
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    id_flush  = 1'b1;
                    state_nxt = FETCH;
                end else if (!id_stall) begin
                    id_load   = 1'b1;
                    ld_pc     = buf_pc;
                    ld_pc4    = buf_pc4;
                    ld_inst   = buf_inst;
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (id_load),
        .bubble    (id_bubble),
        .flush     (id_flush),
        .load_pc   (ld_pc),
        .load_pc4  (ld_pc4),
        .load_inst (ld_inst),
        .valid     (if_id_valid),
        .pc        (if_id_pc),
        .pc4       (if_id_pc4),
        .inst      (if_id_inst)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (id_load && !id_flush) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (id_stall && if_id_valid) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
